fib_seq_gen: RTL

//  Parametrised recurrence-sequence generator; successor of the fixed 4-bit Fibonacci counter.

---
 rtl/fib_seq_pkg.sv | 15 +
 rtl/seq_term_adder.sv | 13 +
 rtl/fib_seq_gen.sv | 98 +++++++++
 3 files changed

// File: rtl/fib_seq_pkg.sv
// fib_seq_pkg: shared types and constants for the recurrence-sequence generator
package fib_seq_pkg;
  typedef enum logic [1:0] {MODE_FIB, MODE_LUCAS, MODE_TRIB, MODE_CUSTOM} mode_t;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;
  localparam int POL_WRAP    = 0;
  localparam int POL_RESTART = 1;
  localparam int POL_HALT    = 2;
  localparam int FIB_T0   = 0;
  localparam int FIB_T1   = 1;
  localparam int LUCAS_T0 = 2;
  localparam int LUCAS_T1 = 1;
  localparam int TRIB_T0  = 0;
  localparam int TRIB_T1  = 0;
  localparam int TRIB_T2  = 1;
endpackage

// File: rtl/seq_term_adder.sv
// seq_term_adder: 3-operand WIDTH-bit adder; the top bit of each term is a sticky overflow marker
module seq_term_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0] a,
  input  logic [WIDTH:0] b,
  input  logic [WIDTH:0] c,
  output logic [WIDTH:0] sum
);
  logic [WIDTH+1:0] raw;
  assign raw = {2'b0, a[WIDTH-1:0]} + {2'b0, b[WIDTH-1:0]} + {2'b0, c[WIDTH-1:0]};
  assign sum = {(|raw[WIDTH+1:WIDTH]) | a[WIDTH] | b[WIDTH] | c[WIDTH], raw[WIDTH-1:0]};
endmodule

// File: rtl/fib_seq_gen.sv
// fib_seq_gen: Fibonacci/Lucas/Tribonacci/custom sequence source on a valid/ready stream
module fib_seq_gen
  import fib_seq_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int IDX_W      = 6,
  parameter int OVF_POLICY = POL_RESTART
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] seed0,
  input  logic [WIDTH-1:0] seed1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [IDX_W-1:0] out_index,
  output logic             out_last,
  output logic             ovf,
  output logic             done
);
  localparam int TW = WIDTH + 1;
  state_t           state;
  mode_t            mode_q, ld_mode;
  logic [WIDTH-1:0] s0_q, s1_q, ld_s0, ld_s1;
  logic [TW-1:0]    t0, t1, t2, op_c, sum, ld_t0, ld_t1, ld_t2;
  logic             trib, accept, last_term;
  // a restart reload reuses the seeds captured at the last start
  always_comb begin
    ld_mode = start ? mode_t'(mode) : mode_q;
    ld_s0   = start ? seed0 : s0_q;
    ld_s1   = start ? seed1 : s1_q;
    ld_t0   = ld_mode == MODE_LUCAS  ? TW'(LUCAS_T0) :
              ld_mode == MODE_TRIB   ? TW'(TRIB_T0)  :
              ld_mode == MODE_CUSTOM ? {1'b0, ld_s0} : TW'(FIB_T0);
    ld_t1   = ld_mode == MODE_LUCAS  ? TW'(LUCAS_T1) :
              ld_mode == MODE_TRIB   ? TW'(TRIB_T1)  :
              ld_mode == MODE_CUSTOM ? {1'b0, ld_s1} : TW'(FIB_T1);
    ld_t2   = ld_mode == MODE_TRIB ? TW'(TRIB_T2) : '0;
  end
  assign trib      = mode_q == MODE_TRIB;
  assign op_c      = trib ? t2 : '0;
  assign accept    = state == ST_RUN && out_valid && out_ready;
  assign last_term = OVF_POLICY != POL_WRAP && t1[WIDTH];
  assign out_data  = t0[WIDTH-1:0];
  assign out_last  = state == ST_RUN && last_term;
  seq_term_adder #(.WIDTH(WIDTH)) u_add (
    .a  (t0),
    .b  (t1),
    .c  (op_c),
    .sum(sum)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      mode_q    <= MODE_FIB;
      s0_q      <= '0;
      s1_q      <= '0;
      t0        <= '0;
      t1        <= '0;
      t2        <= '0;
      out_valid <= 1'b0;
      out_index <= '0;
      ovf       <= 1'b0;
      done      <= 1'b0;
    end else if (start) begin
      state     <= ST_RUN;
      mode_q    <= ld_mode;
      s0_q      <= seed0;
      s1_q      <= seed1;
      t0        <= ld_t0;
      t1        <= ld_t1;
      t2        <= ld_t2;
      out_valid <= 1'b1;
      out_index <= '0;
      ovf       <= 1'b0;
      done      <= 1'b0;
    end else if (accept) begin
      if (last_term && OVF_POLICY == POL_RESTART) begin
        t0        <= ld_t0;
        t1        <= ld_t1;
        t2        <= ld_t2;
        out_index <= '0;
      end else if (last_term && OVF_POLICY == POL_HALT) begin
        state     <= ST_DONE;
        out_valid <= 1'b0;
        done      <= 1'b1;
      end else begin
        t0        <= t1;
        t1        <= trib ? t2 : sum;
        t2        <= trib ? sum : '0;
        out_index <= out_index + 1'b1;
        if (OVF_POLICY == POL_WRAP && sum[WIDTH]) ovf <= 1'b1;
      end
    end
  end
endmodule
